cg_memory_master: RTL and testbench
===================================

CG_MEMORY_MASTER -- requirements
Module: cg_memory_master

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, data bus width in bits.
- REQ-002: Parameter ADDR_WIDTH, default 32, address bus width in bits.
- REQ-003: Parameter TIMEOUT, default 255, maximum number of memory-side wait cycles per phase before abort; legal range 1..65535.
- REQ-004: i_clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-005: i_rst  input  1  asynchronous, active-high reset.
- REQ-006: i_req_valid  input  1  user request valid.
- REQ-007: o_req_ready  output  1  master can accept a request.
- REQ-008: i_req_we  input  1  1 = write, 0 = read.
- REQ-009: i_req_addr  input  ADDR_WIDTH  request word address.
- REQ-010: i_req_wdata  input  DATA_WIDTH  write data.
- REQ-011: o_rsp_valid  output  1  response valid.
- REQ-012: i_rsp_ready  input  1  user accepts the response.
- REQ-013: o_rsp_we  output  1  response belongs to a write.
- REQ-014: o_rsp_err  output  1  transaction aborted by timeout.
- REQ-015: o_rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
- REQ-016: o_wen, o_wdata_valid  output  1 each  memory write strobe pair.
- REQ-017: o_waddr, o_wdata  output  ADDR_WIDTH, DATA_WIDTH  memory write address and data.
- REQ-018: i_wready  input  1  memory accepts the write in this cycle.
- REQ-019: o_raddr_valid, o_raddr  output  1, ADDR_WIDTH  memory read address phase.
- REQ-020: i_raddr_ready  input  1  memory accepts the read address.
- REQ-021: o_rdata_ready  output  1  master is ready for read data.
- REQ-022: i_rdata_valid, i_rdata  input  1, DATA_WIDTH  memory read data phase.

Function
- REQ-023: The FSM SHALL have the states IDLE, WR, RA, RD and RSP, with exactly one transaction in flight.
- REQ-024: o_req_ready SHALL be 1 only in IDLE; on i_req_valid&o_req_ready, the master SHALL latch we/addr/wdata and move to WR (we=1) or RA (we=0).
- REQ-025: In WR, o_wen and o_wdata_valid SHALL be 1, with o_waddr/o_wdata held at the latched values; i_wready=1 at a rising edge SHALL complete the write and move to RSP.
- REQ-026: In RA, o_raddr_valid SHALL be 1 with o_raddr held; i_raddr_ready=1 SHALL move to RD.
- REQ-027: In RD, o_rdata_ready SHALL be 1; i_rdata_valid=1 SHALL capture i_rdata into o_rsp_rdata and move to RSP.
- REQ-028: i_rdata_valid outside RD SHALL be ignored.
- REQ-029: In RSP, o_rsp_valid SHALL be 1 with o_rsp_we/o_rsp_err/o_rsp_rdata stable; i_rsp_ready=1 SHALL return the FSM to IDLE, and no new request SHALL be accepted in that same cycle.
- REQ-030: Memory-side strobe, address and data outputs SHALL be 0 whenever their phase is inactive, and SHALL not change while their strobe is held.
- REQ-031: A wait counter SHALL clear on every entry to WR, RA or RD and increment each cycle the phase handshake is absent; on reaching TIMEOUT, the master SHALL drop the strobes, move to RSP with o_rsp_err=1 and o_rsp_rdata=0.
- REQ-032: A handshake in the same cycle the counter reaches TIMEOUT SHALL win; the transaction then completes without error.
- REQ-033: Latency with a zero-wait memory: write accepted at edge N SHALL give wen high in cycle N+1 and o_rsp_valid at N+2; read SHALL give o_raddr_valid at N+1, o_rdata_ready at N+2 and o_rsp_valid at N+3 when i_rdata_valid arrives in cycle N+2.
- REQ-034: Transactions SHALL complete in acceptance order; a read issued after a write to the same address SHALL observe the written data.

Reset
- REQ-035: While i_rst=1, the FSM SHALL be IDLE, the counter 0, and every output 0 except o_req_ready, which SHALL be 0 during reset and 1 from the first edge after deassertion.
- REQ-036: Reset asserted mid-transaction SHALL abort it immediately with no response issued; strobes SHALL drop asynchronously.

Verification
- REQ-037: Write addr 0x514, data 0x114, i_wready=1 -> o_wen high for exactly 1 cycle with o_waddr=0x514 and o_wdata=0x114; o_rsp_valid=1 with o_rsp_we=1 and err=0.
- REQ-038: Read 0x514, memory returning 0x114 one cycle after address acceptance -> o_rsp_rdata=0x114, err=0, at N+3.
- REQ-039: Write 0x516<-0xAAAA_AAAA, then write 0x516<-0x314, then read 0x516 -> o_rsp_rdata=0x314.
- REQ-040: TIMEOUT=4 with i_raddr_ready held 0 -> o_raddr_valid high for 4 cycles, then o_rsp_err=1 and o_rsp_rdata=0.
- REQ-041: i_rsp_ready=0 for 3 cycles in RSP -> o_rsp_valid and data held stable, o_req_ready=0 throughout.
- REQ-042: i_rst pulsed while in RD -> all outputs 0; a subsequent read of 0x514 completes normally.

Source files
------------

// File: rtl/cg_memory_master.sv
// Single-outstanding memory master: bridges a valid/ready request/response
// port onto a split write / read-address / read-data memory interface,
// with a per-phase wait timeout that aborts the transaction with an error.
module cg_memory_master #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic                  o_rsp_we,
   output logic                  o_rsp_err,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_wen,
   output logic                  o_wdata_valid,
   output logic [ADDR_WIDTH-1:0] o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   input  logic                  i_wready,
   output logic                  o_raddr_valid,
   output logic [ADDR_WIDTH-1:0] o_raddr,
   input  logic                  i_raddr_ready,
   output logic                  o_rdata_ready,
   input  logic                  i_rdata_valid,
   input  logic [DATA_WIDTH-1:0] i_rdata
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RA, S_RD, S_RSP} state_t;

   state_t                state_q, state_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
   logic                  rsp_we_nxt, rsp_err_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                  expired;
   logic                  wr_nxt, ra_nxt;

   // State, wait counter and latched request
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
      end
   end

   // Next state, wait counting and response payload; handshake beats timeout
   always_comb begin
      state_nxt     = state_q;
      cnt_nxt       = cnt_q;
      addr_nxt      = addr_q;
      wdata_nxt     = wdata_q;
      rsp_we_nxt    = o_rsp_we;
      rsp_err_nxt   = o_rsp_err;
      rsp_rdata_nxt = o_rsp_rdata;
      expired       = (cnt_q == CNT_LAST);
      case (state_q)
         S_IDLE: begin
            if (i_req_valid && o_req_ready) begin
               addr_nxt  = i_req_addr;
               wdata_nxt = i_req_we ? i_req_wdata : '0;
               cnt_nxt   = '0;
               state_nxt = i_req_we ? S_WR : S_RA;
            end
         end
         S_WR: begin
            if (i_wready || expired) begin
               state_nxt     = S_RSP;
               rsp_we_nxt    = 1'b1;
               rsp_err_nxt   = !i_wready;
               rsp_rdata_nxt = '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         S_RA: begin
            if (i_raddr_ready) begin
               state_nxt = S_RD;
               cnt_nxt   = '0;
            end else if (expired) begin
               state_nxt     = S_RSP;
               rsp_we_nxt    = 1'b0;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         S_RD: begin
            if (i_rdata_valid || expired) begin
               state_nxt     = S_RSP;
               rsp_we_nxt    = 1'b0;
               rsp_err_nxt   = !i_rdata_valid;
               rsp_rdata_nxt = i_rdata_valid ? i_rdata : '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         S_RSP: begin
            if (i_rsp_ready) begin
               state_nxt     = S_IDLE;
               cnt_nxt       = '0;
               rsp_we_nxt    = 1'b0;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = '0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      wr_nxt = (state_nxt == S_WR);
      ra_nxt = (state_nxt == S_RA);
   end

   // Registered outputs decoded from next state; idle phases drive zero
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_req_ready   <= 1'b0;
         o_rsp_valid   <= 1'b0;
         o_rsp_we      <= 1'b0;
         o_rsp_err     <= 1'b0;
         o_rsp_rdata   <= '0;
         o_wen         <= 1'b0;
         o_wdata_valid <= 1'b0;
         o_waddr       <= '0;
         o_wdata       <= '0;
         o_raddr_valid <= 1'b0;
         o_raddr       <= '0;
         o_rdata_ready <= 1'b0;
      end else begin
         o_req_ready   <= (state_nxt == S_IDLE);
         o_rsp_valid   <= (state_nxt == S_RSP);
         o_rsp_we      <= rsp_we_nxt;
         o_rsp_err     <= rsp_err_nxt;
         o_rsp_rdata   <= rsp_rdata_nxt;
         o_wen         <= wr_nxt;
         o_wdata_valid <= wr_nxt;
         o_waddr       <= wr_nxt ? addr_nxt : '0;
         o_wdata       <= wr_nxt ? wdata_nxt : '0;
         o_raddr_valid <= ra_nxt;
         o_raddr       <= ra_nxt ? addr_nxt : '0;
         o_rdata_ready <= (state_nxt == S_RD);
      end
   end

endmodule

// File: tb/tb_cg_memory_master.sv
// Directed bench for cg_memory_master: write/read latency, read-after-write,
// timeouts, handshake-at-limit, response backpressure and reset abort.
module tb_cg_memory_master;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_valid, i_req_we, i_rsp_ready, i_wready;
   logic          i_raddr_ready, i_rdata_valid;
   logic [AW-1:0] i_req_addr;
   logic [DW-1:0] i_req_wdata, i_rdata;
   logic          o_req_ready, o_rsp_valid, o_rsp_we, o_rsp_err;
   logic [DW-1:0] o_rsp_rdata, o_wdata;
   logic          o_wen, o_wdata_valid, o_raddr_valid, o_rdata_ready;
   logic [AW-1:0] o_waddr, o_raddr;
   logic [135:0]  all_outs;

   logic [DW-1:0] mem [logic [AW-1:0]];
   int nvec = 0;
   int nerr = 0;

   assign all_outs = {o_req_ready, o_rsp_valid, o_rsp_we, o_rsp_err, o_rsp_rdata,
                      o_wen, o_wdata_valid, o_waddr, o_wdata,
                      o_raddr_valid, o_raddr, o_rdata_ready};

   cg_memory_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_we(o_rsp_we),
      .o_rsp_err(o_rsp_err), .o_rsp_rdata(o_rsp_rdata),
      .o_wen(o_wen), .o_wdata_valid(o_wdata_valid), .o_waddr(o_waddr),
      .o_wdata(o_wdata), .i_wready(i_wready),
      .o_raddr_valid(o_raddr_valid), .o_raddr(o_raddr), .i_raddr_ready(i_raddr_ready),
      .o_rdata_ready(o_rdata_ready), .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write transaction; waits = cycles with i_wready low before the accepting cycle
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input bit exp_err);
      nvec++;
      if (o_req_ready !== 1'b1) begin
         nerr++; $display("FAIL wr_req_ready: got %b want 1", o_req_ready);
      end
      i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = a; i_req_wdata = d; i_wready = 1'b0;
      step();
      i_req_valid = 1'b0; i_req_wdata = '0; i_req_addr = '0;
      for (int c = 0; c <= waits; c++) begin
         if (c == waits && exp_err) break;
         nvec++;
         if (o_wen !== 1'b1 || o_wdata_valid !== 1'b1 || o_waddr !== a || o_wdata !== d) begin
            nerr++;
            $display("FAIL wr_strobe c%0d: wen=%b wdv=%b waddr=%h wdata=%h, want 1 1 %h %h",
                     c, o_wen, o_wdata_valid, o_waddr, o_wdata, a, d);
         end
         if (c == waits) begin
            i_wready = 1'b1;
            mem[o_waddr] = o_wdata;
         end
         step();
      end
      i_wready = 1'b0;
      nvec++;
      if (o_rsp_valid !== 1'b1 || o_rsp_we !== 1'b1 || o_rsp_err !== exp_err ||
          o_rsp_rdata !== '0 || o_wen !== 1'b0 || o_waddr !== '0 || o_wdata !== '0) begin
         nerr++;
         $display("FAIL wr_rsp %h: valid=%b we=%b err=%b rdata=%h wen=%b waddr=%h, want 1 1 %b 0 0 0",
                  a, o_rsp_valid, o_rsp_we, o_rsp_err, o_rsp_rdata, o_wen, o_waddr, exp_err);
      end
      i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      nvec++;
      if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
         nerr++; $display("FAIL wr_done: rsp_valid=%b req_ready=%b want 0 1", o_rsp_valid, o_req_ready);
      end
   endtask

   // Read transaction; spurious read data is driven during the address phase
   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input int waits, input bit exp_err, input int hold);
      nvec++;
      if (o_req_ready !== 1'b1) begin
         nerr++; $display("FAIL rd_req_ready: got %b want 1", o_req_ready);
      end
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = a; i_req_wdata = 32'hFFFF_FFFF;
      step();
      i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0;
      i_rdata_valid = 1'b1; i_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c <= waits; c++) begin
         if (c == waits && exp_err) break;
         nvec++;
         if (o_raddr_valid !== 1'b1 || o_raddr !== a || o_rdata_ready !== 1'b0) begin
            nerr++;
            $display("FAIL rd_addr c%0d: raddr_valid=%b raddr=%h rdata_ready=%b, want 1 %h 0",
                     c, o_raddr_valid, o_raddr, o_rdata_ready, a);
         end
         if (c == waits) i_raddr_ready = 1'b1;
         step();
      end
      i_raddr_ready = 1'b0; i_rdata_valid = 1'b0; i_rdata = '0;
      if (!exp_err) begin
         nvec++;
         if (o_rdata_ready !== 1'b1 || o_raddr_valid !== 1'b0 || o_raddr !== '0 || o_rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rd_data_phase: rdata_ready=%b raddr_valid=%b raddr=%h rsp_valid=%b, want 1 0 0 0",
                     o_rdata_ready, o_raddr_valid, o_raddr, o_rsp_valid);
         end
         i_rdata_valid = 1'b1; i_rdata = mem[a];
         step();
         i_rdata_valid = 1'b0; i_rdata = '0;
      end
      for (int h = 0; h <= hold; h++) begin
         i_req_valid = (h < hold); i_req_we = 1'b1; i_req_addr = 32'h0000_0999;
         nvec++;
         if (o_rsp_valid !== 1'b1 || o_rsp_we !== 1'b0 || o_rsp_err !== exp_err ||
             o_rsp_rdata !== exp || o_req_ready !== 1'b0 || o_rdata_ready !== 1'b0 ||
             o_raddr_valid !== 1'b0 || o_wen !== 1'b0) begin
            nerr++;
            $display("FAIL rd_rsp %h h%0d: valid=%b we=%b err=%b rdata=%h req_ready=%b rdr=%b rav=%b wen=%b, want 1 0 %b %h 0 0 0 0",
                     a, h, o_rsp_valid, o_rsp_we, o_rsp_err, o_rsp_rdata, o_req_ready,
                     o_rdata_ready, o_raddr_valid, o_wen, exp_err, exp);
         end
         if (h < hold) step();
      end
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      nvec++;
      if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_wen !== 1'b0 || o_raddr_valid !== 1'b0) begin
         nerr++;
         $display("FAIL rd_done: rsp_valid=%b req_ready=%b wen=%b rav=%b want 0 1 0 0",
                  o_rsp_valid, o_req_ready, o_wen, o_raddr_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_req_valid = 0; i_req_we = 0; i_req_addr = '0; i_req_wdata = '0; i_rsp_ready = 0;
      i_wready = 0; i_raddr_ready = 0; i_rdata_valid = 0; i_rdata = '0;
      step(); step();
      nvec++;
      if (all_outs !== '0) begin
         nerr++; $display("FAIL reset_outs: got %h want 0", all_outs);
      end
      rst = 1'b0;
      #1;
      nvec++;
      if (o_req_ready !== 1'b0) begin
         nerr++; $display("FAIL reset_ready_pre_edge: got %b want 0", o_req_ready);
      end
      step();
      nvec++;
      if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
         nerr++; $display("FAIL reset_ready_post_edge: req_ready=%b rsp_valid=%b want 1 0", o_req_ready, o_rsp_valid);
      end
   endtask

   task automatic test_basic();
      do_write(32'h514, 32'h114, 0, 1'b0);
      do_read(32'h514, 32'h114, 0, 1'b0, 0);
   endtask

   task automatic test_read_after_write();
      do_write(32'h516, 32'hAAAA_AAAA, 0, 1'b0);
      do_write(32'h516, 32'h314, 0, 1'b0);
      do_read(32'h516, 32'h314, 0, 1'b0, 0);
   endtask

   task automatic test_timeout();
      do_read(32'h600, 32'h0, TO, 1'b1, 0);
      do_write(32'h700, 32'h55, TO, 1'b1);
   endtask

   task automatic test_handshake_at_limit();
      do_write(32'h518, 32'h77, TO - 1, 1'b0);
      do_read(32'h518, 32'h77, TO - 1, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      do_read(32'h514, 32'h114, 0, 1'b0, 3);
   endtask

   task automatic test_reset_mid_rd();
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h514;
      step();
      i_req_valid = 1'b0; i_raddr_ready = 1'b1;
      step();
      i_raddr_ready = 1'b0;
      nvec++;
      if (o_rdata_ready !== 1'b1) begin
         nerr++; $display("FAIL rst_mid_in_rd: rdata_ready=%b want 1", o_rdata_ready);
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if (all_outs !== '0) begin
         nerr++; $display("FAIL rst_mid_async: got %h want 0", all_outs);
      end
      step();
      rst = 1'b0;
      i_rdata_valid = 1'b1; i_rdata = 32'h1234_5678;
      step();
      i_rdata_valid = 1'b0; i_rdata = '0;
      nvec++;
      if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rdata_ready !== 1'b0) begin
         nerr++;
         $display("FAIL rst_mid_after: req_ready=%b rsp_valid=%b rdata_ready=%b want 1 0 0",
                  o_req_ready, o_rsp_valid, o_rdata_ready);
      end
      do_read(32'h514, 32'h114, 0, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_read_after_write();
      test_timeout();
      test_handshake_at_limit();
      test_backpressure();
      test_reset_mid_rd();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1);
   end

endmodule
